approx_err_monitor: RTL and testbench
=====================================

# approx_err_monitor

Streaming error-metric accumulator that sits directly downstream of the 16-bit approximate ripple-carry adders. Each accepted sample carries the two operands and the approximate adder's 17-bit sum. The block computes the exact sum internally and accumulates error statistics over a programmed number of samples: error count, sum of absolute error, sum of squared error and maximum absolute error. It is the hardware counterpart of the area/MSE characterisation flow, so an approximate adder can be scored in simulation or on FPGA against a stimulus stream.

## Interface
- WIDTH, 16, operand width; sums are WIDTH+1 bits
- CNT_W, 32, sample-counter width

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; synchronous and active-low
- start  in  1  one-cycle pulse; clears statistics and begins a run
- num_samples  in  CNT_W  samples per run; sampled when start is taken
- in_valid  in  1  sample present on in_a/in_b/in_approx
- in_ready  out  1  block accepts a sample this cycle
- in_a, in_b  in  WIDTH  operands fed to the adder under test
- in_approx  in  WIDTH+1  approximate sum produced by the adder under test
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; statistics are final
- sample_cnt  out  CNT_W  samples accepted this run
- err_cnt  out  CNT_W  samples with in_approx ≠ exact
- max_abs_err  out  WIDTH+1  largest |error| this run
- sum_abs_err  out  CNT_W+WIDTH+1  Σ|error|
- sum_sq_err  out  CNT_W+2*WIDTH+2  Σerror²

## Operation
- Handshake: a sample is accepted on a rising edge where in_valid && in_ready. in_ready = (state==RUN) && (sample_cnt < target). in_ready does not depend on in_valid.
- Arithmetic:
  - exact = in_a + in_b, zero-extended to WIDTH+1.
  - error = in_approx − exact, computed signed at WIDTH+2 bits.
  - |error| ≤ 2^(WIDTH+1)−1. The square fits 2*(WIDTH+1) bits.
  - Accumulator widths are sized so that no overflow occurs for ≤ 2^CNT_W−1 samples. No saturation logic.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start; captures target = num_samples and clears all statistics.
  - If num_samples = 0, the start goes IDLE → DONE directly and statistics are cleared.
  - RUN → DRAIN on the edge where the accepted sample makes sample_cnt = target.
  - DRAIN → DONE once both pipeline stages are empty (2 cycles after the last accept).
  - DONE → RUN/DONE on a new start, with the same clear and capture as from IDLE. Otherwise DONE holds and the outputs stay stable.
- start is ignored in RUN and DRAIN.
- sample_cnt increments at accept. The other statistics update at pipeline retirement.
- max_abs_err updates only when the new |error| is strictly greater than the stored value.

## Timing
- Pipeline:
  - S1 registers exact, error and |error| at the accept edge t.
  - S2 registers |error|² and the error flag at t+1.
  - The accumulators update at t+2, so a sample is visible in the statistics outputs after edge t+2.
- Full throughput: one sample per cycle with in_valid held high.
- Gaps: bubbles propagate as invalid stage bits. Statistics are unaffected.
- Reset (rst_n low at an edge, including mid-run):
  - state = IDLE, pipeline valid bits = 0.
  - All outputs are 0: in_ready, busy, done and all statistics.
  - In-flight samples are discarded.
- done rises on the edge entering DONE and stays high until the next accepted start or reset.
- A start in DONE clears statistics on that edge, and in_ready rises the following cycle.
- Simultaneous start and rst_n low: reset wins.

## Test plan
- Exact stream:
  - Stimulus: num_samples = 4; in_approx = in_a + in_b for (1,2), (0xFFFF,1), (0,0), (0x8000,0x8000).
  - Required: done; sample_cnt = 4; err_cnt = 0; sum_abs_err = 0; sum_sq_err = 0; max_abs_err = 0.
- Mixed errors:
  - Stimulus: num_samples = 3; samples (a=1, b=1, approx=0), (a=2, b=3, approx=8), (a=5, b=5, approx=10).
  - Required: err_cnt = 2; sum_abs_err = 5; sum_sq_err = 13; max_abs_err = 3.
- Worst case:
  - Stimulus: a = b = 0xFFFF, approx = 0.
  - Required: max_abs_err = 0x1FFFE; sum_sq_err = 0x3FFF80004.
- Handshake:
  - Stimulus: num_samples = 5, in_valid toggled randomly.
  - Required: exactly 5 accepts; in_ready = 0 after the 5th; busy ends and done rises exactly 2 cycles after the last accept; a start pulse during RUN changes nothing.
- Zero samples and restart:
  - Stimulus: start with num_samples = 0.
  - Required: DONE next cycle, in_ready never high.
  - Then: start again with num_samples = 2 → statistics cleared and a fresh run completes.
- Reset mid-run:
  - Stimulus: rst_n low for 1 cycle after the 3rd accept of 10.
  - Required: all outputs 0 and state IDLE next cycle; a new run with num_samples = 1 gives sample_cnt = 1.

Source files
------------

// File: rtl/approx_err_monitor.sv
// Scores an approximate adder against the exact sum; stats retire 2 edges after accept.
// in_ready is held low outside RUN and once the programmed number of samples has been taken.
module approx_err_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_samples,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic [WIDTH:0]            in_approx,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          sample_cnt,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [WIDTH:0]            max_abs_err,
  output logic [CNT_W+WIDTH:0]      sum_abs_err,
  output logic [CNT_W+2*WIDTH+1:0]  sum_sq_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_nx;

  logic [CNT_W-1:0]        target;
  logic                    start_take;
  logic                    accept;

  logic [WIDTH:0]          exact_c;
  logic signed [WIDTH+1:0] err_c;
  logic [WIDTH:0]          abs_c;

  logic                    s1_vld;
  logic signed [WIDTH+1:0] s1_err;
  logic [WIDTH:0]          s1_abs;
  logic [2*WIDTH+1:0]      abs_ext;

  logic                    s2_vld;
  logic                    s2_flag;
  logic [WIDTH:0]          s2_abs;
  logic [2*WIDTH+1:0]      s2_sq;

  assign start_take = start && ((state == IDLE) || (state == DONE));
  assign in_ready   = (state == RUN) && (sample_cnt < target);
  assign accept     = in_valid && in_ready;

  assign exact_c = {1'b0, in_a} + {1'b0, in_b};
  assign err_c   = $signed({1'b0, in_approx}) - $signed({1'b0, exact_c});
  // Magnitude taken from an unsigned compare so it never needs the extra sign bit.
  assign abs_c   = (in_approx < exact_c) ? (exact_c - in_approx) : (in_approx - exact_c);
  assign abs_ext = {{(WIDTH+1){1'b0}}, s1_abs};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (num_samples == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (accept && (sample_cnt == target - CNT_ONE)) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // S2 retires on this edge, so the pipeline is empty once S1 is.
        if (!s1_vld) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = (num_samples == '0) ? DONE : RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target      <= '0;
      s1_vld      <= 1'b0;
      s1_err      <= '0;
      s1_abs      <= '0;
      s2_vld      <= 1'b0;
      s2_flag     <= 1'b0;
      s2_abs      <= '0;
      s2_sq       <= '0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_err <= err_c;
        s1_abs <= abs_c;
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_flag <= (s1_err != '0);
        s2_abs  <= s1_abs;
        s2_sq   <= abs_ext * abs_ext;
      end

      if (start_take) begin
        target      <= num_samples;
        sample_cnt  <= '0;
        err_cnt     <= '0;
        max_abs_err <= '0;
        sum_abs_err <= '0;
        sum_sq_err  <= '0;
      end else begin
        if (accept) sample_cnt <= sample_cnt + CNT_ONE;
        if (s2_vld) begin
          err_cnt     <= err_cnt + {{(CNT_W-1){1'b0}}, s2_flag};
          sum_abs_err <= sum_abs_err + {{CNT_W{1'b0}}, s2_abs};
          sum_sq_err  <= sum_sq_err + {{CNT_W{1'b0}}, s2_sq};
          if (s2_abs > max_abs_err) max_abs_err <= s2_abs;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed and randomized runs of approx_err_monitor scored against a plain-arithmetic reference.
module tb_approx_err_monitor;
  localparam int WIDTH = 16;
  localparam int CNT_W = 32;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [CNT_W-1:0]         num_samples;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic [WIDTH:0]           in_approx;
  logic                     busy;
  logic                     done;
  logic [CNT_W-1:0]         sample_cnt;
  logic [CNT_W-1:0]         err_cnt;
  logic [WIDTH:0]           max_abs_err;
  logic [CNT_W+WIDTH:0]     sum_abs_err;
  logic [CNT_W+2*WIDTH+1:0] sum_sq_err;

  int checks = 0;
  int errors = 0;

  int qa[$];
  int qb[$];
  int qx[$];

  longint m_cnt, m_err, m_abs, m_sq, m_max;

  approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .max_abs_err(max_abs_err), .sum_abs_err(sum_abs_err),
    .sum_sq_err(sum_sq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_abs = 0; m_sq = 0; m_max = 0;
  endtask

  task automatic model_add(input int a, input int b, input int x);
    longint e;
    e = longint'(x) - (longint'(a) + longint'(b));
    if (e < 0) e = -e;
    m_cnt++;
    if (e != 0) m_err++;
    m_abs += e;
    m_sq  += e * e;
    if (e > m_max) m_max = e;
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".sample_cnt"}, 66'(sample_cnt), 66'(m_cnt));
    check({tag, ".err_cnt"}, 66'(err_cnt), 66'(m_err));
    check({tag, ".sum_abs"}, 66'(sum_abs_err), 66'(m_abs));
    check({tag, ".sum_sq"}, 66'(sum_sq_err), 66'(m_sq));
    check({tag, ".max_abs"}, 66'(max_abs_err), 66'(m_max));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".in_ready"}, 66'(in_ready), 66'(0));
    check({tag, ".busy"}, 66'(busy), 66'(0));
    check({tag, ".done"}, 66'(done), 66'(0));
    model_clear();
    check_stats(tag);
  endtask

  task automatic push(input int a, input int b, input int x);
    qa.push_back(a); qb.push_back(b); qx.push_back(x);
  endtask

  task automatic push_rand(input int n);
    int a, b, ex, sel, x;
    for (int i = 0; i < n; i++) begin
      a   = int'($urandom_range(16'hFFFF));
      b   = int'($urandom_range(16'hFFFF));
      ex  = a + b;
      sel = int'($urandom_range(3));
      if (sel == 0)      x = ex;
      else if (sel == 1) x = ex ^ int'($urandom_range(255));
      else               x = int'($urandom_range(17'h1FFFF));
      push(a, b, x);
    end
  endtask

  // Runs one programmed pass over the queued samples and scores the result.
  task automatic run(input string tag, input int n, input int vld_pct, input bit poke);
    int idx;
    int guard;
    bit acc;
    idx = 0;
    guard = 0;
    model_clear();
    num_samples = CNT_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_start"}, 66'(busy), 66'(1));
    check_stats({tag, ".clr"});
    while (idx < n && guard < 1000) begin
      in_valid  = ($urandom_range(99) < vld_pct);
      in_a      = WIDTH'(qa[idx]);
      in_b      = WIDTH'(qb[idx]);
      in_approx = (WIDTH+1)'(qx[idx]);
      if (poke && idx == 2) begin
        start = 1'b1;
        num_samples = CNT_W'(7);
      end
      #4;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      num_samples = CNT_W'(n);
      if (acc) begin
        model_add(qa[idx], qb[idx], qx[idx]);
        idx++;
        check({tag, ".scnt"}, 66'(sample_cnt), 66'(idx));
      end
      guard++;
    end
    check({tag, ".accepts"}, 66'(idx), 66'(n));
    check({tag, ".rdy_off"}, 66'(in_ready), 66'(0));
    check({tag, ".done_t0"}, 66'(done), 66'(0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy_t1"}, 66'(busy), 66'(1));
    check({tag, ".done_t1"}, 66'(done), 66'(0));
    @(posedge clk); #1;
    check({tag, ".done_t2"}, 66'(done), 66'(1));
    check({tag, ".busy_t2"}, 66'(busy), 66'(0));
    check({tag, ".rdy_t2"}, 66'(in_ready), 66'(0));
    check_stats(tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".done_hold"}, 66'(done), 66'(1));
    check_stats({tag, ".hold"});
    qa.delete(); qb.delete(); qx.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    in_a = '0; in_b = '0; in_approx = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    push(1, 2, 3); push('hFFFF, 1, 'h10000); push(0, 0, 0); push('h8000, 'h8000, 'h10000);
    run("exact", 4, 100, 1'b0);
    check("exact.err_cnt_const", 66'(err_cnt), 66'(0));

    push(1, 1, 0); push(2, 3, 8); push(5, 5, 10);
    run("mixed", 3, 100, 1'b0);
    check("mixed.err_const", 66'(err_cnt), 66'(2));
    check("mixed.abs_const", 66'(sum_abs_err), 66'(5));
    check("mixed.sq_const", 66'(sum_sq_err), 66'(13));
    check("mixed.max_const", 66'(max_abs_err), 66'(3));

    push('hFFFF, 'hFFFF, 0);
    run("worst", 1, 100, 1'b0);
    check("worst.max_const", 66'(max_abs_err), 66'h1FFFE);
    check("worst.sq_const", 66'(sum_sq_err), 66'h3FFF80004);

    push_rand(5);
    run("handshake", 5, 50, 1'b1);

    push_rand(24);
    run("rand_full", 24, 100, 1'b0);
    push_rand(16);
    run("rand_gaps", 16, 70, 1'b0);

    // Zero-length run from DONE: stats must clear with no samples taken.
    num_samples = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    check("zero.done", 66'(done), 66'(1));
    check("zero.busy", 66'(busy), 66'(0));
    check_stats("zero");
    for (int i = 0; i < 3; i++) begin
      check("zero.rdy", 66'(in_ready), 66'(0));
      @(posedge clk); #1;
    end
    push_rand(2);
    run("restart", 2, 100, 1'b0);

    // Reset three accepts into a ten-sample run, with a competing start.
    num_samples = CNT_W'(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = WIDTH'($urandom_range(16'hFFFF));
      in_b = WIDTH'($urandom_range(16'hFFFF));
      in_approx = (WIDTH+1)'($urandom_range(17'h1FFFF));
      @(posedge clk); #1;
    end
    check("rst_mid.scnt3", 66'(sample_cnt), 66'(3));
    in_valid = 1'b0;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    check_zero("rst_mid");
    @(posedge clk); #1;
    check_zero("rst_mid_flush");
    push(3, 4, 9);
    run("post_rst", 1, 100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
